io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Sequences the shared data port between the CPU load/store path and the UART program loader.
- Routes each granted access to data RAM (1-cycle synchronous read) or to memory-mapped IO. IO space is addresses with bits [31:10] = 22'h3FFFFF; the device is selected by address bits [7:4].
- Stalls the CPU until its access completes, and times out unresponsive IO devices.
- Sits between the CPU datapath and the RAM/LED/switch/tube blocks.

Parameters:
- ADDR_WIDTH, 14, word-address width of data RAM.
- NUM_IO_DEVICES, 3, number of valid IO indices (0 LED, 1 switch, 2 tube).
- TIMEOUT_CYCLES, 255, maximum cycles to wait for iIoAck; must be >= 1.

Ports:
- iClock  in  1  system clock, rising edge.
- iReset  in  1  synchronous, active-high reset.
- iCpuReq  in  1  CPU access request; held stable until oCpuDone.
- iCpuWrite  in  1  1 = store, 0 = load.
- iCpuAddr  in  32  CPU byte address.
- iCpuWData  in  32  store data.
- oCpuRData  out  32  load data; valid while oCpuDone=1.
- oCpuDone  out  1  one-cycle completion pulse.
- oCpuStall  out  1  equals iCpuReq & ~oCpuDone (combinational).
- oCpuBusError  out  1  valid with oCpuDone; 1 = timeout or bad IO index.
- iLoadReq  in  1  loader write request.
- iLoadAddr  in  ADDR_WIDTH  loader word address.
- iLoadWData  in  32  loader write data.
- oLoadAck  out  1  one-cycle pulse; the write was performed this cycle.
- oMemAddr  out  ADDR_WIDTH  RAM word address.
- oMemWData  out  32  RAM write data.
- oMemWrite  out  1  RAM write enable.
- iMemRData  in  32  RAM read data, valid one cycle after oMemAddr.
- oIoSel  out  16  one-hot IO device select.
- oIoWrite  out  1  IO write strobe (level, held while waiting).
- oIoRead  out  1  IO read strobe (level, held while waiting).
- oIoWData  out  32  IO write data.
- iIoRData  in  32  IO read data; sampled when iIoAck=1.
- iIoAck  in  1  device completion.

Behaviour:
- All outputs are registered, except oCpuStall.
- FSM states: IDLE, MEM_WR, MEM_RD, MEM_RESP, IO_WAIT, LOAD, DONE.
- Reset (any state, mid-operation included): state=IDLE; all outputs 0; timeout counter 0; fairness flag lastWasLoad=0. An in-flight access is abandoned with no oCpuDone.
- IDLE arbitration (request sampled at cycle T):
  - Loader wins if iLoadReq && !(iCpuReq && lastWasLoad); otherwise CPU wins if iCpuReq.
  - With both requests continuously asserted, grants alternate.
  - Requests are examined only in IDLE; there is no preemption.
- LOAD (T+1):
  - oMemAddr=iLoadAddr, oMemWData=iLoadWData, oMemWrite=1, oLoadAck=1.
  - Set lastWasLoad=1; go to IDLE.
- Any CPU grant clears lastWasLoad.
- CPU memory address (iCpuAddr[31:10] != 22'h3FFFFF): oMemAddr=iCpuAddr[ADDR_WIDTH+1:2]; bits [1:0] are ignored.
  - Store: MEM_WR at T+1 (oMemWrite=1), then DONE at T+2.
  - Load: MEM_RD at T+1 (address driven), then MEM_RESP at T+2 (iMemRData captured into oCpuRData), then DONE at T+3.
  - Address bits above ADDR_WIDTH+1 are ignored (wrap).
- CPU IO address, with idx=iCpuAddr[7:4]:
  - If idx >= NUM_IO_DEVICES: go DONE at T+1 with oCpuBusError=1, oCpuRData=0; no strobe.
  - Otherwise IO_WAIT from T+1: oIoSel=1<<idx, oIoWrite=iCpuWrite, oIoRead=~iCpuWrite, oIoWData=iCpuWData; counter starts at 0 and increments each IO_WAIT cycle.
  - iIoAck=1: capture iIoRData (0 for writes), drop strobes, go DONE next cycle.
  - Counter reaches TIMEOUT_CYCLES without ack: drop strobes, oCpuBusError=1, oCpuRData=0, go DONE.
  - Ack on the same cycle as the timeout: ack wins, no error.
- DONE: oCpuDone=1 for exactly one cycle, then IDLE. All memory/IO strobes are 0 in DONE and IDLE.
- iCpuReq still high in the IDLE cycle after DONE is a new request.
- A CPU that drops iCpuReq mid-access is ignored; the access completes.

Test Plan:
- CPU load, addr 0x00000010, RAM word 4 = 0xDEADBEEF -> oMemAddr=4 at T+1; oCpuDone=1 with oCpuRData=0xDEADBEEF at T+3; oCpuStall high T..T+2.
- CPU store 0x12345678 to 0x00000020 -> oMemWrite=1 with oMemAddr=8 at T+1; oCpuDone at T+2; oCpuBusError=0.
- CPU load from 0xFFFFFC10, device acks after 4 cycles with 0x00AA -> oIoSel=16'h0002 and oIoRead=1 during wait; oCpuRData=0x00AA on done; no error.
- CPU store to 0xFFFFFC20, no ack, TIMEOUT_CYCLES=8 -> oIoSel=16'h0004 for 8 cycles; oCpuDone with oCpuBusError=1. Separately, store to 0xFFFFFC50 -> error done at T+1, oIoSel never nonzero.
- iLoadReq and iCpuReq both held high from reset release -> order LOAD, CPU access, LOAD, CPU access; each oLoadAck is a single pulse.
- iReset asserted during IO_WAIT -> next cycle state IDLE, oIoSel=0, no oCpuDone; a subsequent request proceeds normally.

Source files
------------

// File: rtl/io_bus_arbiter_if.sv
// Shared data-port bundle between CPU/loader requesters and the arbiter.
// Carries the RAM and memory-mapped IO sides of the port as well.
interface io_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  iCpuReq;
    logic                  iCpuWrite;
    logic [31:0]           iCpuAddr;
    logic [31:0]           iCpuWData;
    logic [31:0]           oCpuRData;
    logic                  oCpuDone;
    logic                  oCpuStall;
    logic                  oCpuBusError;
    logic                  iLoadReq;
    logic [ADDR_WIDTH-1:0] iLoadAddr;
    logic [31:0]           iLoadWData;
    logic                  oLoadAck;
    logic [ADDR_WIDTH-1:0] oMemAddr;
    logic [31:0]           oMemWData;
    logic                  oMemWrite;
    logic [31:0]           iMemRData;
    logic [15:0]           oIoSel;
    logic                  oIoWrite;
    logic                  oIoRead;
    logic [31:0]           oIoWData;
    logic [31:0]           iIoRData;
    logic                  iIoAck;

    modport master (
        output iCpuReq, iCpuWrite, iCpuAddr, iCpuWData,
        output iLoadReq, iLoadAddr, iLoadWData,
        output iMemRData, iIoRData, iIoAck,
        input  oCpuRData, oCpuDone, oCpuStall, oCpuBusError,
        input  oLoadAck, oMemAddr, oMemWData, oMemWrite,
        input  oIoSel, oIoWrite, oIoRead, oIoWData
    );

    modport slave (
        input  iCpuReq, iCpuWrite, iCpuAddr, iCpuWData,
        input  iLoadReq, iLoadAddr, iLoadWData,
        input  iMemRData, iIoRData, iIoAck,
        output oCpuRData, oCpuDone, oCpuStall, oCpuBusError,
        output oLoadAck, oMemAddr, oMemWData, oMemWrite,
        output oIoSel, oIoWrite, oIoRead, oIoWData
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Shares the data port between the CPU and the UART loader, routing CPU
// accesses to data RAM or memory-mapped IO with an ack timeout.
module io_bus_arbiter #(
    parameter int ADDR_WIDTH     = 14,
    parameter int NUM_IO_DEVICES = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             iClock,
    input logic             iReset,
    io_bus_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, MEM_WR, MEM_RD, MEM_RESP, IO_WAIT, LOAD, DONE
    } stateT;

    stateT                 state, stateNext;
    logic [CW-1:0]         count, countNext;
    logic                  lastWasLoad, lastWasLoadNext;
    logic [ADDR_WIDTH-1:0] memAddr, memAddrNext;
    logic [31:0]           memWData, memWDataNext;
    logic                  memWrite, memWriteNext;
    logic                  loadAck, loadAckNext;
    logic                  cpuDone, cpuDoneNext;
    logic                  cpuBusError, cpuBusErrorNext;
    logic [31:0]           cpuRData, cpuRDataNext;
    logic [15:0]           ioSel, ioSelNext;
    logic                  ioWrite, ioWriteNext;
    logic                  ioRead, ioReadNext;
    logic [31:0]           ioWData, ioWDataNext;

    logic       isIo;
    logic [3:0] ioIdx;
    logic       ioValid;
    logic       loadWins;
    logic       unusedAddr;

    assign isIo     = (bus.iCpuAddr[31:10] == 22'h3FFFFF);
    assign ioIdx    = bus.iCpuAddr[7:4];
    assign ioValid  = {28'd0, ioIdx} < 32'(NUM_IO_DEVICES);
    // Fairness: a pending CPU request beats the loader right after a load.
    assign loadWins = bus.iLoadReq && !(bus.iCpuReq && lastWasLoad);
    assign unusedAddr = ^bus.iCpuAddr[1:0];

    always_comb begin
        stateNext       = state;
        countNext       = count;
        lastWasLoadNext = lastWasLoad;
        memAddrNext     = memAddr;
        memWDataNext    = memWData;
        memWriteNext    = 1'b0;
        loadAckNext     = 1'b0;
        cpuDoneNext     = 1'b0;
        cpuBusErrorNext = 1'b0;
        cpuRDataNext    = cpuRData;
        ioSelNext       = ioSel;
        ioWriteNext     = ioWrite;
        ioReadNext      = ioRead;
        ioWDataNext     = ioWData;
        unique case (state)
            IDLE: begin
                if (loadWins) begin
                    stateNext       = LOAD;
                    memAddrNext     = bus.iLoadAddr;
                    memWDataNext    = bus.iLoadWData;
                    memWriteNext    = 1'b1;
                    loadAckNext     = 1'b1;
                    lastWasLoadNext = 1'b1;
                end else if (bus.iCpuReq) begin
                    lastWasLoadNext = 1'b0;
                    if (!isIo) begin
                        memAddrNext = bus.iCpuAddr[ADDR_WIDTH+1:2];
                        if (bus.iCpuWrite) begin
                            stateNext    = MEM_WR;
                            memWDataNext = bus.iCpuWData;
                            memWriteNext = 1'b1;
                        end else begin
                            stateNext = MEM_RD;
                        end
                    end else if (!ioValid) begin
                        stateNext       = DONE;
                        cpuDoneNext     = 1'b1;
                        cpuBusErrorNext = 1'b1;
                        cpuRDataNext    = 32'd0;
                    end else begin
                        stateNext   = IO_WAIT;
                        countNext   = '0;
                        ioSelNext   = 16'd1 << ioIdx;
                        ioWriteNext = bus.iCpuWrite;
                        ioReadNext  = ~bus.iCpuWrite;
                        ioWDataNext = bus.iCpuWData;
                    end
                end
            end
            LOAD: stateNext = IDLE;
            MEM_WR: begin
                stateNext   = DONE;
                cpuDoneNext = 1'b1;
            end
            MEM_RD: stateNext = MEM_RESP;
            MEM_RESP: begin
                stateNext    = DONE;
                cpuDoneNext  = 1'b1;
                cpuRDataNext = bus.iMemRData;
            end
            IO_WAIT: begin
                if (bus.iIoAck || count == LAST) begin
                    stateNext   = DONE;
                    cpuDoneNext = 1'b1;
                    ioSelNext   = 16'd0;
                    ioWriteNext = 1'b0;
                    ioReadNext  = 1'b0;
                    // An ack on the final cycle still counts as success.
                    if (bus.iIoAck) begin
                        cpuRDataNext = ioRead ? bus.iIoRData : 32'd0;
                    end else begin
                        cpuBusErrorNext = 1'b1;
                        cpuRDataNext    = 32'd0;
                    end
                end else begin
                    countNext = count + 1'b1;
                end
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state       <= IDLE;
            count       <= '0;
            lastWasLoad <= 1'b0;
            memAddr     <= '0;
            memWData    <= 32'd0;
            memWrite    <= 1'b0;
            loadAck     <= 1'b0;
            cpuDone     <= 1'b0;
            cpuBusError <= 1'b0;
            cpuRData    <= 32'd0;
            ioSel       <= 16'd0;
            ioWrite     <= 1'b0;
            ioRead      <= 1'b0;
            ioWData     <= 32'd0;
        end else begin
            state       <= stateNext;
            count       <= countNext;
            lastWasLoad <= lastWasLoadNext;
            memAddr     <= memAddrNext;
            memWData    <= memWDataNext;
            memWrite    <= memWriteNext;
            loadAck     <= loadAckNext;
            cpuDone     <= cpuDoneNext;
            cpuBusError <= cpuBusErrorNext;
            cpuRData    <= cpuRDataNext;
            ioSel       <= ioSelNext;
            ioWrite     <= ioWriteNext;
            ioRead      <= ioReadNext;
            ioWData     <= ioWDataNext;
        end
    end

    assign bus.oCpuRData    = cpuRData;
    assign bus.oCpuDone     = cpuDone;
    assign bus.oCpuStall    = bus.iCpuReq & ~cpuDone;
    assign bus.oCpuBusError = cpuBusError;
    assign bus.oLoadAck     = loadAck;
    assign bus.oMemAddr     = memAddr;
    assign bus.oMemWData    = memWData;
    assign bus.oMemWrite    = memWrite;
    assign bus.oIoSel       = ioSel;
    assign bus.oIoWrite     = ioWrite;
    assign bus.oIoRead      = ioRead;
    assign bus.oIoWData     = ioWData;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed and random accesses compared
// against a transaction-level model of latency, data and errors.
module tb_io_bus_arbiter;
    localparam int AW  = 14;
    localparam int NIO = 3;
    localparam int TMO = 8;

    logic clk;
    logic rst;
    int checks = 0;
    int errors = 0;

    bit   [31:0] ram [1<<AW];
    logic [31:0] refMem [int];

    io_bus_arbiter_if #(.ADDR_WIDTH(AW)) bus();

    io_bus_arbiter #(
        .ADDR_WIDTH(AW),
        .NUM_IO_DEVICES(NIO),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .iClock(clk),
        .iReset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data RAM with one-cycle synchronous read
    always @(posedge clk) begin
        if (bus.oMemWrite === 1'b1) ram[bus.oMemAddr] <= bus.oMemWData;
        bus.iMemRData <= ram[bus.oMemAddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refRead(input int w);
        return refMem.exists(w) ? refMem[w] : 32'h0;
    endfunction

    task automatic doLoad(input int w, input logic [31:0] d);
        bus.iLoadReq   = 1'b1;
        bus.iLoadAddr  = w[AW-1:0];
        bus.iLoadWData = d;
        tick();
        check("load_ack", 32'(bus.oLoadAck), 32'd1);
        check("load_we", 32'(bus.oMemWrite), 32'd1);
        check("load_addr", 32'(bus.oMemAddr), 32'(w[AW-1:0]));
        check("load_data", bus.oMemWData, d);
        bus.iLoadReq = 1'b0;
        tick();
        check("load_ack_pulse", 32'(bus.oLoadAck), 32'd0);
        refMem[w] = d;
    endtask

    task automatic cpuAccess(input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ackDelay,
                             input logic [31:0] ackData, input bit dropReq);
        bit          isIo;
        int          idx;
        int          word;
        int          expLat;
        bit          expErr;
        bit          chkData;
        logic [31:0] expData;
        logic [15:0] expSel;
        int          lat;
        int          ioCyc;
        isIo    = (addr[31:10] == 22'h3FFFFF);
        idx     = int'(addr[7:4]);
        word    = int'(addr[AW+1:2]);
        expErr  = 1'b0;
        chkData = 1'b1;
        expData = 32'h0;
        expSel  = 16'h0;
        expLat  = 0;
        if (!isIo) begin
            expLat  = wr ? 2 : 3;
            chkData = !wr;
            expData = refRead(word);
        end else if (idx >= NIO) begin
            expLat = 1;
            expErr = 1'b1;
        end else begin
            expSel = 16'd1 << idx;
            if (ackDelay >= 1 && ackDelay <= TMO) begin
                expLat  = ackDelay + 1;
                expData = wr ? 32'h0 : ackData;
            end else begin
                expLat = TMO + 1;
                expErr = 1'b1;
            end
        end
        bus.iCpuReq   = 1'b1;
        bus.iCpuWrite = wr;
        bus.iCpuAddr  = addr;
        bus.iCpuWData = wdata;
        #1;
        check("stall_req", 32'(bus.oCpuStall), 32'd1);
        lat   = 0;
        ioCyc = 0;
        while (bus.oCpuDone !== 1'b1 && lat < 400) begin
            tick();
            lat++;
            if (lat == 1 && dropReq) bus.iCpuReq = 1'b0;
            if (lat == 1 && !isIo) begin
                check("mem_addr", 32'(bus.oMemAddr), 32'(word));
                check("mem_we", 32'(bus.oMemWrite), 32'(wr));
                if (wr) check("mem_wdata", bus.oMemWData, wdata);
            end
            if (bus.oIoSel !== 16'h0) begin
                ioCyc++;
                check("io_sel", 32'(bus.oIoSel), 32'(expSel));
                check("io_rd", 32'(bus.oIoRead), 32'(!wr));
                check("io_wr", 32'(bus.oIoWrite), 32'(wr));
                if (wr) check("io_wdata", bus.oIoWData, wdata);
                bus.iIoAck   = (ioCyc == ackDelay);
                bus.iIoRData = ackData;
            end else begin
                bus.iIoAck = 1'b0;
            end
            if (bus.oCpuDone !== 1'b1 && bus.iCpuReq === 1'b1)
                check("stall_wait", 32'(bus.oCpuStall), 32'd1);
        end
        bus.iIoAck = 1'b0;
        check("latency", 32'(lat), 32'(expLat));
        check("bus_err", 32'(bus.oCpuBusError), 32'(expErr));
        if (chkData) check("rdata", bus.oCpuRData, expData);
        if (isIo && idx < NIO)
            check("io_cycles", 32'(ioCyc), 32'(expErr ? TMO : ackDelay));
        if (isIo && idx >= NIO)
            check("bad_idx_nosel", 32'(ioCyc), 32'd0);
        if (bus.iCpuReq === 1'b1)
            check("stall_done", 32'(bus.oCpuStall), 32'd0);
        bus.iCpuReq = 1'b0;
        if (!isIo && wr) refMem[word] = wdata;
        tick();
        check("done_pulse", 32'(bus.oCpuDone), 32'd0);
        check("idle_we", 32'(bus.oMemWrite), 32'd0);
        check("idle_sel", 32'(bus.oIoSel), 32'd0);
    endtask

    initial begin
        int evC[$];
        int evK[$];
        int expC[$];
        int expK[$];
        int dbl;
        int n;
        int t;
        int kind;
        bit lw;
        bit prevAck;
        bit wr;
        bit drop;
        logic [31:0] a;

        rst            = 1'b1;
        bus.iCpuReq    = 1'b0;
        bus.iCpuWrite  = 1'b0;
        bus.iCpuAddr   = 32'h0;
        bus.iCpuWData  = 32'h0;
        bus.iLoadReq   = 1'b0;
        bus.iLoadAddr  = '0;
        bus.iLoadWData = 32'h0;
        bus.iIoRData   = 32'h0;
        bus.iIoAck     = 1'b0;
        tick();
        tick();
        check("rst_done", 32'(bus.oCpuDone), 32'd0);
        check("rst_err", 32'(bus.oCpuBusError), 32'd0);
        check("rst_rdata", bus.oCpuRData, 32'h0);
        check("rst_ack", 32'(bus.oLoadAck), 32'd0);
        check("rst_we", 32'(bus.oMemWrite), 32'd0);
        check("rst_maddr", 32'(bus.oMemAddr), 32'd0);
        check("rst_mwdata", bus.oMemWData, 32'h0);
        check("rst_sel", 32'(bus.oIoSel), 32'd0);
        check("rst_iord", 32'(bus.oIoRead), 32'd0);
        check("rst_iowr", 32'(bus.oIoWrite), 32'd0);
        check("rst_iowdata", bus.oIoWData, 32'h0);
        check("rst_stall", 32'(bus.oCpuStall), 32'd0);
        rst = 1'b0;
        tick();

        doLoad(4, 32'hDEADBEEF);
        cpuAccess(1'b0, 32'h0000_0010, 32'h0, 0, 32'h0, 1'b0);
        cpuAccess(1'b1, 32'h0000_0020, 32'h1234_5678, 0, 32'h0, 1'b0);
        cpuAccess(1'b0, 32'h0000_0020, 32'h0, 0, 32'h0, 1'b0);
        cpuAccess(1'b0, 32'h0001_0010, 32'h0, 0, 32'h0, 1'b0);
        cpuAccess(1'b0, 32'hFFFF_FC10, 32'h0, 4, 32'h0000_00AA, 1'b0);
        cpuAccess(1'b1, 32'hFFFF_FC20, 32'h55, 0, 32'h0, 1'b0);
        cpuAccess(1'b1, 32'hFFFF_FC50, 32'h66, 0, 32'h0, 1'b0);
        cpuAccess(1'b0, 32'hFFFF_FC00, 32'h0, TMO, 32'h77, 1'b0);
        cpuAccess(1'b1, 32'hFFFF_FC10, 32'h99, 1, 32'hFF, 1'b1);

        // Both requesters held from reset release
        rst            = 1'b1;
        bus.iLoadReq   = 1'b1;
        bus.iLoadAddr  = 14'd100;
        bus.iLoadWData = 32'hA5A5_0001;
        bus.iCpuReq    = 1'b1;
        bus.iCpuWrite  = 1'b1;
        bus.iCpuAddr   = 32'h0000_0200;
        bus.iCpuWData  = 32'h5A5A_0002;
        tick();
        tick();
        rst     = 1'b0;
        dbl     = 0;
        prevAck = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.oLoadAck === 1'b1) begin
                evC.push_back(c);
                evK.push_back(0);
                if (prevAck) dbl++;
            end
            if (bus.oCpuDone === 1'b1) begin
                evC.push_back(c);
                evK.push_back(1);
            end
            prevAck = (bus.oLoadAck === 1'b1);
        end
        t  = 0;
        lw = 1'b0;
        while (expC.size() < 4) begin
            if (!lw) begin
                expC.push_back(t + 1);
                expK.push_back(0);
                t += 2;
            end else begin
                expC.push_back(t + 2);
                expK.push_back(1);
                t += 3;
            end
            lw = !lw;
        end
        for (int i = 0; i < 4; i++) begin
            check("arb_cycle", 32'(evC.size() > i ? evC[i] : -1),
                  32'(expC[i]));
            check("arb_kind", 32'(evK.size() > i ? evK[i] : -1),
                  32'(expK[i]));
        end
        check("ack_single", 32'(dbl), 32'd0);
        bus.iLoadReq = 1'b0;
        bus.iCpuReq  = 1'b0;
        refMem[100]  = 32'hA5A5_0001;
        refMem[128]  = 32'h5A5A_0002;
        tick();
        tick();
        cpuAccess(1'b0, 32'h0000_0190, 32'h0, 0, 32'h0, 1'b0);
        cpuAccess(1'b0, 32'h0000_0200, 32'h0, 0, 32'h0, 1'b0);

        // Reset in the middle of an IO wait
        bus.iCpuReq   = 1'b1;
        bus.iCpuWrite = 1'b0;
        bus.iCpuAddr  = 32'hFFFF_FC00;
        tick();
        check("mid_sel", 32'(bus.oIoSel), 32'h1);
        check("mid_rd", 32'(bus.oIoRead), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_sel", 32'(bus.oIoSel), 32'd0);
        check("mid_rst_rd", 32'(bus.oIoRead), 32'd0);
        check("mid_rst_done", 32'(bus.oCpuDone), 32'd0);
        rst         = 1'b0;
        bus.iCpuReq = 1'b0;
        n           = 0;
        repeat (5) begin
            tick();
            if (bus.oCpuDone === 1'b1) n++;
        end
        check("mid_no_done", 32'(n), 32'd0);
        cpuAccess(1'b0, 32'hFFFF_FC20, 32'h0, 2, 32'hC0DE, 1'b0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            wr   = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 3) == 0);
            case (kind)
                0: doLoad($urandom_range(0, 15), $urandom);
                1, 2: begin
                    a = {16'($urandom), 14'($urandom_range(0, 15)),
                         2'($urandom)};
                    cpuAccess(kind == 1, a, $urandom, 0, 32'h0, drop);
                end
                3: begin
                    a = {22'h3FFFFF, 2'($urandom),
                         4'($urandom_range(0, NIO - 1)), 4'($urandom)};
                    cpuAccess(wr, a, $urandom, $urandom_range(0, TMO + 2),
                              $urandom, drop);
                end
                default: begin
                    a = {22'h3FFFFF, 2'($urandom),
                         4'($urandom_range(NIO, 15)), 4'($urandom)};
                    cpuAccess(wr, a, $urandom, 1, $urandom, drop);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
